hole_sensor_bank: RTL



---
 rtl/hole_sensor_bank.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hole_sensor_bank.sv
// Debounced, edge-detected bank of pinball hole sensors with ball, hit and last-hole tracking.
// Define HOLE_LOCK_EN to let each hole score only once per game (locks clear in the RESET state).
module hole_sensor_bank #(
    parameter int NUM_HOLES  = 8,
    parameter int DB_DEPTH   = 4,
    parameter int BALLS_INIT = 8,
    parameter int CNT_W      = 4,
    parameter int HIT_W      = 8,
    parameter int IDX_W      = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_HOLES-1:0]       ball,
    input  logic [2:0]                 state,
    output logic [CNT_W-1:0]           ball_num,
    output logic [NUM_HOLES-1:0]       getball,
    output logic                       hit_valid,
    output logic [IDX_W-1:0]           last_hole,
    output logic [NUM_HOLES*HIT_W-1:0] hit_count,
    output logic                       game_over
);

    localparam int NW = $clog2(NUM_HOLES + 1);
    localparam int SW = (NW > CNT_W) ? NW : CNT_W;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_GET   = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    logic [NUM_HOLES-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_HOLES-1:0] db_q, db_d, getball_q, getball_d;
    logic [DB_DEPTH-1:0]  sh_q [NUM_HOLES];
    logic [DB_DEPTH-1:0]  sh_d [NUM_HOLES];
    logic [HIT_W-1:0]     hit_q [NUM_HOLES];
    logic [HIT_W-1:0]     hit_d [NUM_HOLES];
    logic [CNT_W-1:0]     ball_num_q, ball_num_d;
    logic [IDX_W-1:0]     last_hole_q, last_hole_d, low_idx;
    logic                 hit_valid_q, hit_valid_d;
    logic [SW-1:0]        n;
    logic                 is_get, is_reset;
`ifdef HOLE_LOCK_EN
    logic [NUM_HOLES-1:0] lock_q, lock_d;
`endif

    assign is_get   = (state == ST_GET);
    assign is_reset = (state == ST_RESET);

    // Hysteresis: db only changes once the whole window agrees.
    always_comb begin
        sync1_d = ball;
        sync2_d = sync1_q;
        for (int i = 0; i < NUM_HOLES; i++) begin
            sh_d[i] = {sh_q[i][DB_DEPTH-2:0], sync2_q[i]};
            if (&sh_q[i])
                db_d[i] = 1'b1;
            else if (~|sh_q[i])
                db_d[i] = 1'b0;
            else
                db_d[i] = db_q[i];
        end
`ifdef HOLE_LOCK_EN
        getball_d = db_d & ~db_q & ~lock_q;
        lock_d    = is_reset ? '0 : (is_get ? (lock_q | getball_q) : lock_q);
`else
        getball_d = db_d & ~db_q;
`endif
    end

    always_comb begin
        n       = '0;
        low_idx = '0;
        for (int i = 0; i < NUM_HOLES; i++)
            n = n + SW'(getball_q[i]);
        for (int i = NUM_HOLES - 1; i >= 0; i--)
            if (getball_q[i]) low_idx = IDX_W'(i);
    end

    // NOTE: every output of this block is given a default first, so no path leaves a latch.
    always_comb begin
        ball_num_d  = ball_num_q;
        last_hole_d = last_hole_q;
        hit_valid_d = 1'b0;
        hit_d       = hit_q;
        if (is_reset) begin
            ball_num_d  = CNT_W'(BALLS_INIT);
            last_hole_d = '0;
            for (int i = 0; i < NUM_HOLES; i++) hit_d[i] = '0;
        end else if (is_get && (n != '0)) begin
            ball_num_d  = (SW'(ball_num_q) >= n) ? CNT_W'(SW'(ball_num_q) - n) : '0;
            last_hole_d = low_idx;
            hit_valid_d = 1'b1;
            for (int i = 0; i < NUM_HOLES; i++)
                if (getball_q[i] && (hit_q[i] != '1)) hit_d[i] = hit_q[i] + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            getball_q   <= '0;
            ball_num_q  <= CNT_W'(BALLS_INIT);
            last_hole_q <= '0;
            hit_valid_q <= 1'b0;
            // NOTE: these arrays are per-channel flops, not RAM, so they take the async reset too.
            for (int i = 0; i < NUM_HOLES; i++) begin
                sh_q[i]  <= '0;
                hit_q[i] <= '0;
            end
`ifdef HOLE_LOCK_EN
            lock_q      <= '0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            getball_q   <= getball_d;
            ball_num_q  <= ball_num_d;
            last_hole_q <= last_hole_d;
            hit_valid_q <= hit_valid_d;
            sh_q        <= sh_d;
            hit_q       <= hit_d;
`ifdef HOLE_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM_HOLES; g++) begin : g_pack
        assign hit_count[g*HIT_W +: HIT_W] = hit_q[g];
    end

    assign ball_num  = ball_num_q;
    assign getball   = getball_q;
    assign hit_valid = hit_valid_q;
    assign last_hole = last_hole_q;
    assign game_over = (ball_num_q == '0) && !is_reset;

endmodule
